key_decoder: RTL and testbench
==============================

KEY_DECODER -- requirements
Module: key_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: character FIFO entries; power of two, minimum 2.
REQ-002 Parameter OUT_WIDTH, default 16: key_out width; minimum 8; code zero-extended.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 scan_ready  input  1  PS/2 receiver byte strobe; rising edge marks a new scan_code.
REQ-006 scan_code  input  8  set-2 scan byte; stable while scan_ready high.
REQ-007 key_out  output  OUT_WIDTH  Hack keyboard level: code of held key, 0 when none.
REQ-008 char_valid  output  1  FIFO head valid.
REQ-009 char_data  output  8  FIFO head code; 0 when char_valid=0.
REQ-010 char_ready  input  1  consumer pop request.
REQ-011 caps  output  1  caps-lock state (LED drive).
REQ-012 overflow  output  1  sticky: a push was dropped on full FIFO.

Function
REQ-013 scan_ready SHALL pass a 2-flop history; a byte is consumed on the edge where history==01 (2nd clk edge after scan_ready rises); all outputs change on that edge.
REQ-014 Prefix FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK.
REQ-015 Transitions: F0: IDLE->BRK, EXT->EXT_BRK; E0: IDLE->EXT, BRK->EXT_BRK; any other byte is decoded then state->IDLE; E1 ignored, state unchanged.
REQ-016 Modifiers: 12 (L shift), 59 (R shift) tracked separately, set on make, cleared on break; shift = L|R; E0 12 ignored.
REQ-017 58 (caps) SHALL toggle caps on make only when caps not already held; caps-held cleared on break; no push.
REQ-018 14, 11, 77, 7E and all unmapped codes SHALL produce no push and leave key_out unchanged.
REQ-019 Letters: upper case (65-90) when shift XOR caps, else lower (97-122).
REQ-020 Non-letters: US layout; shift selects symbol (1->33 ... 0->41, - ->95, = ->43, [ ->123, ] ->125, \ ->124, ; ->58, ' ->34, , ->60, . ->62, / ->63, ` ->126), unshifted gives base char; caps has no effect.
REQ-021 Specials: 5A->128, 66->129, 76->140, F1-F12->141-152, 0D->9, 29->32; keypad (non-extended) digits/operators as plain chars, shift ignored.
REQ-022 Extended: 6B 130, 75 131, 74 132, 72 133, 6C 134, 69 135, 7D 136, 7A 137, 70 138, 71 139, E0 5A ->128, E0 4A ->47.
REQ-023 Mapped make: key_out <= code; held scan byte and ext flag recorded; one FIFO push of code.
REQ-024 Break: key_out <= 0 only if byte and ext flag match the recorded held key; other breaks leave key_out unchanged.
REQ-025 FIFO: push/pop same edge when both occur; pop when char_valid&&char_ready; no fall-through, char_valid rises one edge after push into empty FIFO.
REQ-026 Full: push without pop dropped, overflow <= 1; full with simultaneous pop accepts push, count unchanged.
REQ-027 Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.

Reset
REQ-028 reset SHALL immediately clear FSM to IDLE, scan history, modifiers, caps, held key, key_out, FIFO (char_valid 0, char_data 0), overflow.
REQ-029 Reset mid-sequence (after F0/E0) SHALL discard the prefix; next byte decoded as a fresh make.

Configuration
REQ-030 KEY_DECODER_TYPEMATIC_EN defined: every repeated make of the held key pushes again (auto-repeat).
REQ-031 Undefined: make matching the recorded held key is suppressed (no push, key_out unchanged); push again only after its break or a different make.

Verification
REQ-032 Bytes 1C, F0 1C -> push 97, key_out 97 then 0; char_valid one edge after push.
REQ-033 12, 1C, F0 12, 58, 1C -> pushes 65, 97? no: 65 then 65 (caps on); caps=1; 12,1C with caps -> 97.
REQ-034 E0 75, E0 F0 75 -> key_out 131 then 0; 75 alone -> 56.
REQ-035 FIFO_DEPTH=4, char_ready=0, 5 makes -> 4 stored, overflow=1; pop-with-push at full keeps count 4.
REQ-036 1C 1C 1C with held key -> 3 pushes with _EN, 1 without.
REQ-037 Reset asserted after F0 -> all outputs 0; then 1C -> push 97, key_out 97.

Source files
------------

// File: rtl/key_decoder.sv
// key_decoder: PS/2 set-2 scan decoder driving a Hack key level and a char FIFO.
// Define KEY_DECODER_TYPEMATIC_EN to push again on every repeated make of the held key.
module key_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scan_ready,
  input  logic [7:0]           scan_code,
  output logic [OUT_WIDTH-1:0] key_out,
  output logic                 char_valid,
  output logic [7:0]           char_data,
  input  logic                 char_ready,
  output logic                 caps,
  output logic                 overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t      state, state_nxt;
  logic [1:0]  hist;
  logic        stb, dec, mk, bk;
  logic        is_ext, is_brk;
  logic        shift_l, shift_r, caps_held, shift;
  logic        held_vld, held_ext, match;
  logic [7:0]  held_code;
  logic [7:0]  pc, sc_sh, code;
  logic        letter, mapped, push, pop, full, wr;
  logic [AW:0] count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]  mem [FIFO_DEPTH];

  function automatic logic [7:0] plain_map(input logic [7:0] sc);
    logic [7:0] c;
    c = 8'd0;
    case (sc)
      8'h1C: c = 8'd97;  8'h32: c = 8'd98;  8'h21: c = 8'd99;
      8'h23: c = 8'd100; 8'h24: c = 8'd101; 8'h2B: c = 8'd102;
      8'h34: c = 8'd103; 8'h33: c = 8'd104; 8'h43: c = 8'd105;
      8'h3B: c = 8'd106; 8'h42: c = 8'd107; 8'h4B: c = 8'd108;
      8'h3A: c = 8'd109; 8'h31: c = 8'd110; 8'h44: c = 8'd111;
      8'h4D: c = 8'd112; 8'h15: c = 8'd113; 8'h2D: c = 8'd114;
      8'h1B: c = 8'd115; 8'h2C: c = 8'd116; 8'h3C: c = 8'd117;
      8'h2A: c = 8'd118; 8'h1D: c = 8'd119; 8'h22: c = 8'd120;
      8'h35: c = 8'd121; 8'h1A: c = 8'd122;
      8'h16: c = 8'd49;  8'h1E: c = 8'd50;  8'h26: c = 8'd51;
      8'h25: c = 8'd52;  8'h2E: c = 8'd53;  8'h36: c = 8'd54;
      8'h3D: c = 8'd55;  8'h3E: c = 8'd56;  8'h46: c = 8'd57;
      8'h45: c = 8'd48;
      8'h4E: c = 8'd45;  8'h55: c = 8'd61;  8'h54: c = 8'd91;
      8'h5B: c = 8'd93;  8'h5D: c = 8'd92;  8'h4C: c = 8'd59;
      8'h52: c = 8'd39;  8'h41: c = 8'd44;  8'h49: c = 8'd46;
      8'h4A: c = 8'd47;  8'h0E: c = 8'd96;
      8'h5A: c = 8'd128; 8'h66: c = 8'd129; 8'h76: c = 8'd140;
      8'h0D: c = 8'd9;   8'h29: c = 8'd32;
      8'h05: c = 8'd141; 8'h06: c = 8'd142; 8'h04: c = 8'd143;
      8'h0C: c = 8'd144; 8'h03: c = 8'd145; 8'h0B: c = 8'd146;
      8'h83: c = 8'd147; 8'h0A: c = 8'd148; 8'h01: c = 8'd149;
      8'h09: c = 8'd150; 8'h78: c = 8'd151; 8'h07: c = 8'd152;
      // keypad: plain characters, shift has no effect
      8'h70: c = 8'd48;  8'h69: c = 8'd49;  8'h72: c = 8'd50;
      8'h7A: c = 8'd51;  8'h6B: c = 8'd52;  8'h73: c = 8'd53;
      8'h74: c = 8'd54;  8'h6C: c = 8'd55;  8'h75: c = 8'd56;
      8'h7D: c = 8'd57;  8'h71: c = 8'd46;  8'h79: c = 8'd43;
      8'h7B: c = 8'd45;  8'h7C: c = 8'd42;
      default: c = 8'd0;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] shift_map(input logic [7:0] sc);
    logic [7:0] c;
    c = 8'd0;
    case (sc)
      8'h16: c = 8'd33;  8'h1E: c = 8'd64;  8'h26: c = 8'd35;
      8'h25: c = 8'd36;  8'h2E: c = 8'd37;  8'h36: c = 8'd94;
      8'h3D: c = 8'd38;  8'h3E: c = 8'd42;  8'h46: c = 8'd40;
      8'h45: c = 8'd41;  8'h4E: c = 8'd95;  8'h55: c = 8'd43;
      8'h54: c = 8'd123; 8'h5B: c = 8'd125; 8'h5D: c = 8'd124;
      8'h4C: c = 8'd58;  8'h52: c = 8'd34;  8'h41: c = 8'd60;
      8'h49: c = 8'd62;  8'h4A: c = 8'd63;  8'h0E: c = 8'd126;
      default: c = 8'd0;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] ext_map(input logic [7:0] sc);
    logic [7:0] c;
    c = 8'd0;
    case (sc)
      8'h6B: c = 8'd130; 8'h75: c = 8'd131; 8'h74: c = 8'd132;
      8'h72: c = 8'd133; 8'h6C: c = 8'd134; 8'h69: c = 8'd135;
      8'h7D: c = 8'd136; 8'h7A: c = 8'd137; 8'h70: c = 8'd138;
      8'h71: c = 8'd139; 8'h5A: c = 8'd128; 8'h4A: c = 8'd47;
      default: c = 8'd0;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or posedge reset)
    if (reset) hist <= 2'b00;
    else hist <= {hist[0], scan_ready};

  assign stb = hist == 2'b01;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (stb) begin
      unique case (1'b1)
        scan_code == 8'hF0:
          state_nxt = (state == IDLE) ? BRK :
                      (state == EXT) ? EXT_BRK : state;
        scan_code == 8'hE0:
          state_nxt = (state == IDLE) ? EXT :
                      (state == BRK) ? EXT_BRK : state;
        scan_code == 8'hE1: state_nxt = state;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    is_ext = state inside {EXT, EXT_BRK};
    is_brk = state inside {BRK, EXT_BRK};
    dec = stb && !(scan_code inside {8'hF0, 8'hE0, 8'hE1});
    mk = dec && !is_brk;
    bk = dec && is_brk;
  end

  assign shift = shift_l | shift_r;

  always_comb begin
    pc = plain_map(scan_code);
    sc_sh = shift_map(scan_code);
    letter = pc >= 8'd97 && pc <= 8'd122;
    if (is_ext) code = ext_map(scan_code);
    else if (letter && (shift ^ caps)) code = pc - 8'd32;
    else if (shift && sc_sh != 8'd0) code = sc_sh;
    else code = pc;
  end

  assign mapped = code != 8'd0;
  assign match = held_vld && held_code == scan_code && held_ext == is_ext;

`ifdef KEY_DECODER_TYPEMATIC_EN
  assign push = mk && mapped;
`else
  assign push = mk && mapped && !match;
`endif

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      shift_l <= 1'b0;
      shift_r <= 1'b0;
      caps <= 1'b0;
      caps_held <= 1'b0;
    end else if (dec && !is_ext) begin
      if (scan_code == 8'h12) shift_l <= !is_brk;
      if (scan_code == 8'h59) shift_r <= !is_brk;
      if (scan_code == 8'h58) begin
        if (!is_brk && !caps_held) caps <= !caps;
        caps_held <= !is_brk;
      end
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      key_out <= '0;
      held_vld <= 1'b0;
      held_code <= 8'd0;
      held_ext <= 1'b0;
    end else if (push) begin
      key_out <= OUT_WIDTH'(code);
      held_vld <= 1'b1;
      held_code <= scan_code;
      held_ext <= is_ext;
    end else if (bk && match) begin
      key_out <= '0;
      held_vld <= 1'b0;
    end

  assign pop = char_valid && char_ready;
  assign full = count == DEPTH_C;
  assign wr = push && (!full || pop);

  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= code;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !pop) count <= count + 1'b1;
      else if (pop && !wr) count <= count - 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
    end

  assign char_valid = count != '0;
  assign char_data = char_valid ? mem[rd_ptr] : 8'd0;
endmodule

// File: tb/tb_key_decoder.sv
// tb_key_decoder: vector table, directed corner sequences and randomized
// scan streams checked against a table-driven keyboard model.
module tb_key_decoder;
  localparam int DEPTH = 4;
`ifdef KEY_DECODER_TYPEMATIC_EN
  localparam bit TYP = 1'b1;
`else
  localparam bit TYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, scan_ready, char_ready;
  logic [7:0]  scan_code, char_data;
  logic [15:0] key_out;
  logic        char_valid, caps, overflow;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  key_decoder #(.FIFO_DEPTH(DEPTH), .OUT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .scan_ready(scan_ready),
    .scan_code(scan_code), .key_out(key_out),
    .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .caps(caps), .overflow(overflow)
  );

  int letter_t[256], plain_t[256], sym_t[256], ext_t[256];

  function automatic void build();
    string lt, dg, ds, kp;
    int pua[11] = '{45, 61, 91, 93, 92, 59, 39, 44, 46, 47, 96};
    int psa[11] = '{95, 43, 123, 125, 124, 58, 34, 60, 62, 63, 126};
    int lc[26] = '{'h1C, 'h32, 'h21, 'h23, 'h24, 'h2B, 'h34, 'h33, 'h43,
                   'h3B, 'h42, 'h4B, 'h3A, 'h31, 'h44, 'h4D, 'h15, 'h2D,
                   'h1B, 'h2C, 'h3C, 'h2A, 'h1D, 'h22, 'h35, 'h1A};
    int dc[10] = '{'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46, 'h45};
    int pcd[11] = '{'h4E, 'h55, 'h54, 'h5B, 'h5D, 'h4C, 'h52, 'h41, 'h49, 'h4A, 'h0E};
    int kc[14] = '{'h70, 'h69, 'h72, 'h7A, 'h6B, 'h73, 'h74, 'h6C, 'h75, 'h7D,
                   'h71, 'h79, 'h7B, 'h7C};
    int fc[12] = '{'h05, 'h06, 'h04, 'h0C, 'h03, 'h0B, 'h83, 'h0A, 'h01, 'h09, 'h78, 'h07};
    int xc[10] = '{'h6B, 'h75, 'h74, 'h72, 'h6C, 'h69, 'h7D, 'h7A, 'h70, 'h71};
    for (int i = 0; i < 256; i++) begin
      letter_t[i] = 0; plain_t[i] = 0; sym_t[i] = 0; ext_t[i] = 0;
    end
    lt = "abcdefghijklmnopqrstuvwxyz";
    dg = "1234567890";
    ds = "!@#$%^&*()";
    kp = "0123456789.+-*";
    for (int i = 0; i < 26; i++) letter_t[lc[i]] = int'(lt[i]);
    for (int i = 0; i < 10; i++) begin
      plain_t[dc[i]] = int'(dg[i]); sym_t[dc[i]] = int'(ds[i]);
    end
    for (int i = 0; i < 11; i++) begin
      plain_t[pcd[i]] = pua[i]; sym_t[pcd[i]] = psa[i];
    end
    for (int i = 0; i < 14; i++) plain_t[kc[i]] = int'(kp[i]);
    for (int i = 0; i < 12; i++) plain_t[fc[i]] = 141 + i;
    for (int i = 0; i < 10; i++) ext_t[xc[i]] = 130 + i;
    plain_t['h5A] = 128; plain_t['h66] = 129; plain_t['h76] = 140;
    plain_t['h0D] = 9;   plain_t['h29] = 32;
    ext_t['h5A] = 128;   ext_t['h4A] = 47;
  endfunction

  function automatic int lookup(input bit e, input int b, input bit shf, input bit cp);
    if (e) return ext_t[b];
    if (letter_t[b] != 0) return (shf ^ cp) ? letter_t[b] - 32 : letter_t[b];
    if (shf && sym_t[b] != 0) return sym_t[b];
    return plain_t[b];
  endfunction

  bit m_ext, m_brk, m_shl, m_shr, m_caps, m_ch, m_hv, m_he, m_ov;
  int m_hc, m_key, m_push;
  int mq[$];

  function automatic void model_reset();
    m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0; m_caps = 0; m_ch = 0;
    m_hv = 0; m_he = 0; m_ov = 0; m_hc = 0; m_key = 0; m_push = 0;
    mq.delete();
  endfunction

  function automatic void model_byte(input int b);
    bit hit;
    int c;
    if (b == 'hF0) begin m_brk = 1; return; end
    if (b == 'hE0) begin m_ext = 1; return; end
    if (b == 'hE1) return;
    hit = m_hv && m_hc == b && m_he == m_ext;
    if (!m_ext && b == 'h12) m_shl = !m_brk;
    else if (!m_ext && b == 'h59) m_shr = !m_brk;
    else if (!m_ext && b == 'h58) begin
      if (!m_brk && !m_ch) m_caps = !m_caps;
      m_ch = !m_brk;
    end else if (m_brk) begin
      if (hit) begin m_key = 0; m_hv = 0; end
    end else begin
      c = lookup(m_ext, b, m_shl | m_shr, m_caps);
      if (c != 0 && (TYP || !hit)) begin
        m_push = c; m_key = c; m_hv = 1; m_hc = b; m_he = m_ext;
      end
    end
    m_ext = 0; m_brk = 0;
  endfunction

  function automatic void model_edge(input bit cons, input int b, input bit rdy);
    m_push = 0;
    if (rdy && mq.size() != 0) void'(mq.pop_front());
    if (cons) model_byte(b);
    if (m_push != 0) begin
      if (mq.size() < DEPTH) mq.push_back(m_push);
      else m_ov = 1;
    end
  endfunction

  function automatic void chk(input string n, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cycle(input logic sr, input logic [7:0] sc,
                       input logic rdy, input bit cons);
    scan_ready = sr; scan_code = sc; char_ready = rdy;
    @(posedge clk);
    model_edge(cons, int'(sc), rdy);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic r0,
                      input logic r1, input logic r2);
    cycle(1'b1, b, r0, 1'b0);
    cycle(1'b1, b, r1, 1'b1);
    cycle(1'b0, b, r2, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; scan_ready = 1'b0; scan_code = 8'h00; char_ready = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_key"}, 32'(key_out), m_key);
    chk({tag, "_valid"}, 32'(char_valid), 32'(mq.size() != 0));
    chk({tag, "_data"}, 32'(char_data), mq.size() != 0 ? mq[0] : 0);
    chk({tag, "_caps"}, 32'(caps), 32'(m_caps));
    chk({tag, "_ovf"}, 32'(overflow), 32'(m_ov));
  endtask

  typedef struct {
    logic [7:0] b;
    int key;
    int push;
    bit caps;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic [7:0] b, input int k, input int p, input bit c);
    vec_t v;
    v.b = b; v.key = k; v.push = p; v.caps = c;
    tv.push_back(v);
  endtask

  initial begin
    int pool[22] = '{'h1C, 'h32, 'h21, 'h12, 'h59, 'h58, 'h16, 'h1E, 'h4E,
                     'h0E, 'h5A, 'h66, 'h75, 'h6B, 'h70, 'h7C, 'h14, 'h77,
                     'h05, 'h4A, 'h29, 'h0D};
    int exp_d[4] = '{98, 99, 100, 102};
    int n;
    build();
    reset = 1'b1; scan_ready = 1'b0; scan_code = 8'h00; char_ready = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_key", 32'(key_out), 0);
    chk("rst_valid", 32'(char_valid), 0);
    chk("rst_data", 32'(char_data), 0);
    chk("rst_caps", 32'(caps), 0);
    chk("rst_ovf", 32'(overflow), 0);
    reset = 1'b0;
    @(negedge clk);

    add(8'h1C, 97, 97, 0);  add(8'hF0, 97, 0, 0);   add(8'h1C, 0, 0, 0);
    add(8'h12, 0, 0, 0);    add(8'h1C, 65, 65, 0);  add(8'hF0, 65, 0, 0);
    add(8'h12, 65, 0, 0);   add(8'h58, 65, 0, 1);   add(8'hF0, 65, 0, 1);
    add(8'h58, 65, 0, 1);   add(8'hF0, 65, 0, 1);   add(8'h1C, 0, 0, 1);
    add(8'h1C, 65, 65, 1);  add(8'hF0, 65, 0, 1);   add(8'h1C, 0, 0, 1);
    add(8'h12, 0, 0, 1);    add(8'h1C, 97, 97, 1);  add(8'hF0, 97, 0, 1);
    add(8'h12, 97, 0, 1);   add(8'h58, 97, 0, 0);   add(8'hF0, 97, 0, 0);
    add(8'h58, 97, 0, 0);   add(8'hE0, 97, 0, 0);   add(8'h75, 131, 131, 0);
    add(8'hE0, 131, 0, 0);  add(8'hF0, 131, 0, 0);  add(8'h75, 0, 0, 0);
    add(8'h75, 56, 56, 0);  add(8'h16, 49, 49, 0);  add(8'h12, 49, 0, 0);
    add(8'h1E, 64, 64, 0);  add(8'h59, 64, 0, 0);   add(8'hF0, 64, 0, 0);
    add(8'h12, 64, 0, 0);   add(8'h4E, 95, 95, 0);  add(8'hF0, 95, 0, 0);
    add(8'h59, 95, 0, 0);   add(8'h55, 61, 61, 0);  add(8'h5A, 128, 128, 0);
    add(8'hE0, 128, 0, 0);  add(8'h4A, 47, 47, 0);  add(8'h4A, 47, 47, 0);
    add(8'h05, 141, 141, 0); add(8'h07, 152, 152, 0); add(8'h7C, 42, 42, 0);
    add(8'h14, 42, 0, 0);   add(8'hE1, 42, 0, 0);   add(8'h77, 42, 0, 0);
    add(8'hF0, 42, 0, 0);   add(8'h16, 42, 0, 0);   add(8'hE0, 42, 0, 0);
    add(8'h12, 42, 0, 0);   add(8'h0D, 9, 9, 0);    add(8'h29, 32, 32, 0);
    add(8'h66, 129, 129, 0); add(8'h76, 140, 140, 0); add(8'hE0, 140, 0, 0);
    add(8'h6B, 130, 130, 0);

    foreach (tv[i]) begin
      cycle(1'b1, tv[i].b, 1'b1, 1'b0);
      cycle(1'b1, tv[i].b, 1'b1, 1'b1);
      chk($sformatf("tv%0d_key", i), 32'(key_out), tv[i].key);
      chk($sformatf("tv%0d_valid", i), 32'(char_valid), 32'(tv[i].push != 0));
      chk($sformatf("tv%0d_data", i), 32'(char_data), tv[i].push);
      chk($sformatf("tv%0d_caps", i), 32'(caps), 32'(tv[i].caps));
      cycle(1'b0, tv[i].b, 1'b1, 1'b0);
    end

    do_reset();
    cycle(1'b1, 8'h1C, 1'b0, 1'b0);
    chk("rep_pre_valid", 32'(char_valid), 0);
    cycle(1'b1, 8'h1C, 1'b0, 1'b1);
    chk("rep_first_valid", 32'(char_valid), 1);
    cycle(1'b0, 8'h1C, 1'b0, 1'b0);
    send(8'h1C, 1'b0, 1'b0, 1'b0);
    send(8'h1C, 1'b0, 1'b0, 1'b0);
    chk("rep_key", 32'(key_out), 97);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (char_valid) begin
        n++;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
      end
    end
    chk("rep_pushes", n, TYP ? 3 : 1);

    do_reset();
    send(8'h1C, 1'b0, 1'b0, 1'b0);
    send(8'h32, 1'b0, 1'b0, 1'b0);
    send(8'h21, 1'b0, 1'b0, 1'b0);
    send(8'h23, 1'b0, 1'b0, 1'b0);
    chk("full_ovf_before", 32'(overflow), 0);
    send(8'h24, 1'b0, 1'b0, 1'b0);
    chk("full_ovf", 32'(overflow), 1);
    chk("full_head", 32'(char_data), 97);
    send(8'h2B, 1'b0, 1'b1, 1'b0);
    chk("full_ovf_sticky", 32'(overflow), 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), 32'(char_data), exp_d[i]);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(char_valid), 0);
    chk("drain_data0", 32'(char_data), 0);

    do_reset();
    send(8'h58, 1'b0, 1'b0, 1'b0);
    send(8'h1C, 1'b0, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_key", 32'(key_out), 0);
    chk("mid_rst_valid", 32'(char_valid), 0);
    chk("mid_rst_data", 32'(char_data), 0);
    chk("mid_rst_caps", 32'(caps), 0);
    chk("mid_rst_ovf", 32'(overflow), 0);
    do_reset();
    send(8'h1C, 1'b0, 1'b0, 1'b0);
    chk("post_rst_key", 32'(key_out), 97);
    chk("post_rst_valid", 32'(char_valid), 1);
    chk("post_rst_data", 32'(char_data), 97);

    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [7:0] k;
      k = 8'(pool[$urandom_range(0, 21)]);
      if ($urandom_range(0, 15) == 0) send(8'hE1, rb(), rb(), rb());
      if ($urandom_range(0, 3) == 0) send(8'hE0, rb(), rb(), rb());
      if ($urandom_range(0, 2) == 0) send(8'hF0, rb(), rb(), rb());
      send(k, rb(), rb(), rb());
      cmp_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
